// File: rtl/cic2_interp_sdm.sv
// cic2_interp_sdm: 2nd-order CIC interpolator followed by a 1st-order sigma-delta modulator.
// Low-rate samples are differenced twice (comb-comb) once per frame of INTERP_FACTOR
// clocks, zero-stuffed into the first integrator and integrated twice at f_clk. The
// resulting R*x level is turned into a 1-bit density stream by an error-feedback accumulator.
//
// Handshake: a sample transfers on the rising edge where valid_i & ready_o are both high.
// ready_o is high for exactly one cycle per frame (phase 0). valid_i and data_i are ignored
// in every other cycle. A request left unanswered repeats the previous sample and sets
// the sticky underrun_o flag.
module cic2_interp_sdm #(
    parameter int DATA_WIDTH    = 16,
    parameter int INTERP_FACTOR = 10,
    localparam int IW           = DATA_WIDTH + $clog2(INTERP_FACTOR) + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  sdm_o,
    output logic                  sample_clk_o,
    output logic                  underrun_o,
    input  logic                  clear_i,
    output logic [IW-1:0]         integrator2_o
);

    localparam int            PW         = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(INTERP_FACTOR - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(INTERP_FACTOR / 2);
    // Full scale of the modulator: the integrator output peaks just below R*2^DATA_WIDTH.
    localparam logic [IW:0]   FS         = (IW+1)'(longint'(INTERP_FACTOR) << DATA_WIDTH);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic          sample_clk_q;

    logic [IW-1:0] x_prev;
    logic [IW-1:0] c1;
    logic [IW-1:0] c2;
    logic [IW-1:0] int1;
    logic [IW-1:0] int2;
    logic [IW:0]   acc;
    logic          sdm_q;
    logic          underrun_q;

    logic          sample_edge;
    logic          stuff_edge;
    logic [IW-1:0] s_ext;
    logic [IW-1:0] diff;
    logic [IW:0]   sum;

    assign phase_next  = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
    assign sample_edge = (phase == '0);
    // The comb output enters the integrator only on the edge right after the sample edge;
    // on every other edge the zero-stuffed input contributes nothing.
    assign stuff_edge  = (phase == PW'(1));

    // An unanswered request repeats the previous sample, so the comb sees a zero step.
    assign s_ext = valid_i ? IW'(data_i) : x_prev;
    assign diff  = s_ext - x_prev;
    assign sum   = acc + {1'b0, int2};

    // Frame phase counter and the registered low-rate clock derived from it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase        <= '0;
            sample_clk_q <= 1'b1;
        end else begin
            phase        <= phase_next;
            sample_clk_q <= (phase_next < PHASE_HALF);
        end
    end

    // Comb-comb stage, updated once per frame at the sample edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_prev <= '0;
            c1     <= '0;
            c2     <= '0;
        end else if (sample_edge) begin
            x_prev <= s_ext;
            c1     <= diff;
            c2     <= diff - c1;
        end
    end

    // Integrator-integrator stage at full rate; wrap-around arithmetic is intentional.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            int1 <= '0;
            int2 <= '0;
        end else begin
            if (stuff_edge) begin
                int1 <= int1 + c2;
            end
            int2 <= int2 + int1;
        end
    end

    // First-order sigma-delta: emit a one and subtract full scale whenever the sum reaches it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc   <= '0;
            sdm_q <= 1'b0;
        end else if (sum >= FS) begin
            acc   <= sum - FS;
            sdm_q <= 1'b1;
        end else begin
            acc   <= sum;
            sdm_q <= 1'b0;
        end
    end

    // Sticky underrun flag; a new underrun takes priority over clear_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underrun_q <= 1'b0;
        end else if (sample_edge && !valid_i) begin
            underrun_q <= 1'b1;
        end else if (clear_i) begin
            underrun_q <= 1'b0;
        end
    end

    assign ready_o       = sample_edge & ~rst_i;
    assign sdm_o         = sdm_q;
    assign sample_clk_o  = sample_clk_q;
    assign underrun_o    = underrun_q;
    assign integrator2_o = int2;

endmodule

// File: tb/tb_cic2_interp_sdm.sv
// tb_cic2_interp_sdm: directed scenarios plus randomized traffic against a behavioural
// model that describes the interpolator output as a piecewise-linear ramp between samples.
module tb_cic2_interp_sdm;

    localparam int     DW = 16;
    localparam int     R  = 10;
    localparam int     IW = DW + $clog2(R) + 2;
    localparam longint FS = longint'(R) * 65536;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          clear_i;
    logic          ready_o;
    logic          sdm_o;
    logic          sample_clk_o;
    logic          underrun_o;
    logic [IW-1:0] integrator2_o;

    always #5 clk = ~clk;

    cic2_interp_sdm #(.DATA_WIDTH(DW), .INTERP_FACTOR(R)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .sdm_o         (sdm_o),
        .sample_clk_o  (sample_clk_o),
        .underrun_o    (underrun_o),
        .clear_i       (clear_i),
        .integrator2_o (integrator2_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Output level after each edge: the ramp from the sample before last to the last
    // sample finishes one edge after the sample edge; the ramp towards the newest sample
    // starts the edge after that and gains (new-last) per edge.
    int     phase_m;
    int     n_m;
    longint q_prev, q_last, q_new;
    longint int2_m, acc_m, sum_m;
    bit     sdm_m, und_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_m = 0; n_m = 0;
            q_prev = 0; q_last = 0; q_new = 0;
            int2_m = 0; acc_m = 0; sdm_m = 0; und_m = 0;
        end else begin
            sum_m = acc_m + int2_m;
            if (sum_m >= FS) begin sdm_m = 1; acc_m = sum_m - FS; end
            else begin sdm_m = 0; acc_m = sum_m; end
            if (phase_m == 0) begin
                q_prev = q_last;
                q_last = q_new;
                if (valid_i) q_new = longint'(data_i);
                n_m = 0;
                if (!valid_i) und_m = 1;
                else if (clear_i) und_m = 0;
            end else begin
                n_m++;
                if (clear_i) und_m = 0;
            end
            if (n_m == 0) int2_m = R * q_prev + (R - 1) * (q_last - q_prev);
            else          int2_m = R * q_last + (n_m - 1) * (q_new - q_last);
            phase_m = (phase_m + 1) % R;
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("sdm_o", longint'(sdm_o), longint'(sdm_m));
            chk("int2", longint'(integrator2_o), int2_m);
            chk("ready_o", longint'(ready_o), longint'(phase_m == 0));
            chk("sample_clk", longint'(sample_clk_o), longint'(phase_m < R / 2));
            chk("underrun", longint'(underrun_o), longint'(und_m));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!ready_o && guard < 2 * R) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_timeout", longint'(ready_o), 1);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ones += int'(sdm_o);
        end
    endtask

    task automatic count_toggles(input int n, output int toggles);
        logic prev;
        prev = sdm_o;
        toggles = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sdm_o != prev) toggles++;
            prev = sdm_o;
        end
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int     cnt, first_pos, bad, ones, toggles, w1;
        longint prev;
        data_i  = '0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        rst     = 1'b1;
        cycles(3);
        rst     = 1'b0;
        started = 1'b1;

        // 1. free-run handshake: ready once per frame, starting right after release
        cnt = 0; first_pos = -1; bad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ready_o) begin
                cnt++;
                if (first_pos < 0) first_pos = i;
                if (i % R != 0) bad++;
            end
            @(negedge clk);
        end
        chk("ready_count", cnt, 10);
        chk("ready_first", first_pos, 0);
        chk("ready_spacing", bad, 0);

        // 2. constant zero
        data_i = 16'h0000; valid_i = 1'b1;
        pulse_clear();
        cycles(40);
        chk("zero_int2", longint'(integrator2_o), 0);
        count_ones(30, ones);
        chk("zero_ones", ones, 0);
        chk("zero_underrun", longint'(underrun_o), 0);

        // 3. half scale alternates, quarter scale gives one 1 per 4 cycles
        data_i = 16'h8000;
        cycles(40);
        chk("half_int2", longint'(integrator2_o), 327680);
        count_toggles(20, toggles);
        chk("half_toggles", toggles, 20);
        data_i = 16'h4000;
        cycles(40);
        chk("quarter_int2", longint'(integrator2_o), 163840);
        bad = 0;
        for (int w = 0; w < 10; w++) begin
            count_ones(4, w1);
            if (w1 != 1) bad++;
        end
        chk("quarter_windows", bad, 0);

        // 4. step 0 -> 0xFFFF: linear ramp, exact final value, exact long-run density
        data_i = 16'h0000;
        cycles(40);
        chk("pre_step_int2", longint'(integrator2_o), 0);
        wait_ready();
        data_i = 16'hFFFF;
        cycles(3);
        chk("step_e2", longint'(integrator2_o), 65535);
        prev = longint'(integrator2_o);
        for (int k = 3; k <= 11; k++) begin
            @(negedge clk);
            chk("step_slope", longint'(integrator2_o) - prev, 65535);
            prev = longint'(integrator2_o);
        end
        chk("step_e11", longint'(integrator2_o), 655350);
        count_ones(65536, ones);
        chk("full_density", ones, 65535);

        // 5. underrun with 0x8000 held
        data_i = 16'h8000;
        cycles(40);
        pulse_clear();
        chk("und_cleared0", longint'(underrun_o), 0);
        wait_ready();
        valid_i = 1'b0; data_i = 16'h1234;
        @(negedge clk);
        valid_i = 1'b1; data_i = 16'h8000;
        chk("und_set", longint'(underrun_o), 1);
        chk("und_hold_int2", longint'(integrator2_o), 327680);
        count_toggles(20, toggles);
        chk("und_toggles", toggles, 20);
        pulse_clear();
        chk("und_clear", longint'(underrun_o), 0);
        wait_ready();
        valid_i = 1'b0; clear_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b1; clear_i = 1'b0;
        chk("und_set_wins", longint'(underrun_o), 1);
        cycles(5);

        // 6. asynchronous mid-stream reset
        #2 rst = 1'b1;
        #1;
        chk("arst_sdm", longint'(sdm_o), 0);
        chk("arst_int2", longint'(integrator2_o), 0);
        chk("arst_underrun", longint'(underrun_o), 0);
        chk("arst_ready", longint'(ready_o), 0);
        #9 rst = 1'b0;
        #1;
        chk("arst_ready_return", longint'(ready_o), 1);
        cycles(60);
        chk("arst_reramp", longint'(integrator2_o), 327680);

        // randomized traffic: random data every cycle, occasional missed requests and clears
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            data_i  = 16'($urandom);
            valid_i = ($urandom_range(0, 7) != 0);
            clear_i = ($urandom_range(0, 15) == 0);
        end
        valid_i = 1'b1;
        clear_i = 1'b0;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
